// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Holds the FSM state encoding, owner encoding and beat-width helpers.
package mem_arb_pkg;

  // Arbiter FSM states: idle, read burst in progress, write burst in progress
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_t;

  // Owner encoding as stored in the owner register
  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  // Beat geometry for the default 64-bit data width (128-bit bus beat)
  localparam int DATA_WIDTH_DEF = 64;
  localparam int BEAT_BYTES     = DATA_WIDTH_DEF * 2 / 8;
  localparam logic [BEAT_BYTES-1:0] FULL_MASK = '1;

  // Convert a stored owner into the one-hot {m1,m0} grant encoding
  function automatic logic [1:0] owner_onehot(input logic owner);
    return (owner == OWN_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-input winner picker for the memory port arbiter.
// Default: fixed priority, m1 beats m0.
// With ARB_ROUND_ROBIN_EN defined: on contention the master that did not
// win last time (rr_last) is chosen.
module arb_pick (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] win
);

  import mem_arb_pkg::*;

`ifndef ARB_ROUND_ROBIN_EN
  // rr_last only matters in round-robin mode
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
`endif

  // Pick a one-hot winner; a lone requester always wins
  always_comb begin
    win = 2'b00;
    if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = (rr_last == OWN_M1) ? 2'b01 : 2'b10;
`else
      win = 2'b10;
`endif
    end else begin
      win = req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-cache miss unit (m0, reads only)
// and the D-cache miss unit (m1, refill reads and writebacks).
// A grant covers a whole burst of BURST_LEN beats and is never pre-empted.
// Optional round-robin contention handling: define ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      m0_ren,
  input  logic [ADDR_WIDTH-1:0]     m0_raddr,
  output logic                      m0_rvalid,
  output logic [DATA_WIDTH*2-1:0]   m0_rdata,
  input  logic                      m1_ren,
  input  logic [ADDR_WIDTH-1:0]     m1_raddr,
  output logic                      m1_rvalid,
  output logic [DATA_WIDTH*2-1:0]   m1_rdata,
  input  logic                      m1_wen,
  input  logic [ADDR_WIDTH-1:0]     m1_waddr,
  input  logic [DATA_WIDTH*2-1:0]   m1_wdata,
  input  logic [DATA_WIDTH*2/8-1:0] m1_wmask,
  output logic                      m1_wvalid,
  output logic                      ren_mem,
  output logic [ADDR_WIDTH-1:0]     raddr_mem,
  input  logic                      rvalid_mem,
  input  logic [DATA_WIDTH*2-1:0]   rdata_mem,
  output logic                      wen_mem,
  output logic [ADDR_WIDTH-1:0]     waddr_mem,
  output logic [DATA_WIDTH*2-1:0]   wdata_mem,
  output logic [DATA_WIDTH*2/8-1:0] wmask_mem,
  input  logic                      wvalid_mem,
  output logic [1:0]                grant
);

  import mem_arb_pkg::*;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  arb_state_t state;
  logic       owner;
  logic [3:0] cnt;
  logic       rr_last;

  logic [1:0] req_vec;
  logic [1:0] win;
  logic       own_req;
  logic       own_beat;
  logic       rd_active;
  logic       wr_active;

  assign req_vec   = {m1_ren | m1_wen, m0_ren};
  assign rd_active = (state == RD);
  assign wr_active = (state == WR);

  arb_pick u_pick (
    .req     (req_vec),
    .rr_last (rr_last),
    .win     (win)
  );

  // Owner's request level and the valid beat that counts for the current state
  always_comb begin
    own_req  = 1'b0;
    own_beat = 1'b0;
    case (state)
      RD: begin
        own_req  = (owner == OWN_M1) ? m1_ren : m0_ren;
        own_beat = rvalid_mem;
      end
      WR: begin
        own_req  = m1_wen;
        own_beat = wvalid_mem;
      end
      default: begin
        own_req  = 1'b0;
        own_beat = 1'b0;
      end
    endcase
  end

  // Burst FSM: grant in IDLE, count beats, leave on last beat or request drop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      owner <= OWN_M0;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (win[1]) begin
            owner <= OWN_M1;
            state <= m1_ren ? RD : WR;
          end else if (win[0]) begin
            owner <= OWN_M0;
            state <= RD;
          end
        end
        RD, WR: begin
          if (own_beat && ((cnt == LAST_BEAT) || !own_req)) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (own_beat) begin
            cnt <= cnt + 4'd1;
          end else if (!own_req) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the most recent winner so the other master wins next contention
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_last <= OWN_M0;
    end else if ((state == IDLE) && (win != 2'b00)) begin
      rr_last <= win[1] ? OWN_M1 : OWN_M0;
    end
  end
`else
  assign rr_last = OWN_M0;
`endif

  assign grant = (rd_active || wr_active) ? owner_onehot(owner) : 2'b00;

  assign ren_mem   = rd_active & own_req;
  assign raddr_mem = rd_active ? ((owner == OWN_M1) ? m1_raddr : m0_raddr)
                               : '0;
  assign m0_rvalid = rd_active & (owner == OWN_M0) & rvalid_mem;
  assign m1_rvalid = rd_active & (owner == OWN_M1) & rvalid_mem;
  assign m0_rdata  = rdata_mem;
  assign m1_rdata  = rdata_mem;

  assign wen_mem   = wr_active & m1_wen;
  assign waddr_mem = wr_active ? m1_waddr : '0;
  assign wdata_mem = wr_active ? m1_wdata : '0;
  assign wmask_mem = wr_active ? m1_wmask : '0;
  assign m1_wvalid = wr_active & wvalid_mem;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 128-bit memory port between two cache miss units: m0 (I-cache refill, read-only traffic) and m1 (D-cache refill plus writeback).
- Grants the port for a whole burst of BURST_LEN beats and never pre-empts an owner mid-burst.
- Sits between the two miss units and the memory/bus interface; the downstream memory sees exactly one requester.

Parameters:
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64; the bus beat is DATA_WIDTH*2 bits.
- BURST_LEN, 2, beats per burst; supported range 1..15.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m0_ren  in  1  m0 read request; held until its burst ends
- m0_raddr  in  ADDR_WIDTH  m0 beat address; m0 advances it after each rvalid
- m0_rvalid  out  1  read beat valid to m0
- m0_rdata  out  DATA_WIDTH*2  read data to m0
- m1_ren, m1_raddr, m1_rvalid, m1_rdata  as m0_*
- m1_wen  in  1  m1 write request
- m1_waddr  in  ADDR_WIDTH  write beat address
- m1_wdata  in  DATA_WIDTH*2  write data
- m1_wmask  in  DATA_WIDTH*2/8  byte mask
- m1_wvalid  out  1  write beat accepted
- ren_mem / raddr_mem  out  1 / ADDR_WIDTH  read request to memory
- rvalid_mem / rdata_mem  in  1 / DATA_WIDTH*2  read response
- wen_mem / waddr_mem / wdata_mem / wmask_mem  out  write request to memory
- wvalid_mem  in  1  write beat accepted
- grant  out  2  one-hot current owner {m1,m0}; 0 when idle

Behaviour:
- Clocking and reset: single clock clk; reset rstn is asynchronous, active-low.
- Registered state: state, owner, beat counter cnt (4 bits), rr_last.
- On reset: IDLE, cnt=0, rr_last=0.
- Outputs are combinational from the registered state, so during and after reset all outputs are 0: grant, ren_mem, wen_mem, raddr_mem, waddr_mem, wdata_mem, wmask_mem, m0_rvalid, m1_rvalid, m1_wvalid.
- States: IDLE, RD, WR.
- IDLE:
  - Candidates are m0_ren and (m1_ren | m1_wen).
  - Fixed priority: m1 over m0.
  - When m1 is picked, read beats write if both are asserted.
  - The grant registers on the next edge, so arbitration latency is 1 cycle. The memory request appears in the first RD/WR cycle.
- RD (owner X):
  - ren_mem = mX_ren; raddr_mem = mX_raddr.
  - mX_rvalid = rvalid_mem; non-owner rvalid = 0.
  - rdata_mem is broadcast to both mX_rdata.
- WR (owner m1):
  - wen_mem = m1_wen; waddr_mem, wdata_mem and wmask_mem are passed through.
  - m1_wvalid = wvalid_mem.
  - ren_mem = 0.
- Beat counting: each valid beat to the owner increments cnt.
- Burst end: on the beat where cnt==BURST_LEN-1, go to IDLE and clear cnt. Re-arbitration happens next cycle, so the port has at least 1 idle cycle between bursts.
- Abort: if the owner drops its request in RD/WR with no valid beat that cycle, return to IDLE and clear cnt.
- Valid beat and request drop in the same cycle: the beat is delivered and counted, then the abort rule applies.
- Read-then-write sequence (m1 refill then writeback): treated as two separate bursts, each arbitrated.
- rvalid_mem/wvalid_mem in IDLE, or the wrong valid for the state: ignored, not forwarded.
- Reset mid-burst: immediate return to IDLE with all outputs 0. The memory side must tolerate the abandoned burst.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: in IDLE, when both masters request, the master not equal to rr_last wins. rr_last is updated at every grant.
- Undefined: fixed m1-over-m0 priority; rr_last is not implemented.
- Single-requester behaviour is identical in both modes.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, RD, WR};
  - owner encoding constants OWN_M0=0, OWN_M1=1;
  - BEAT_BYTES = DATA_WIDTH*2/8;
  - full-mask constant.
- Sub-module arb_pick: 2-input picker taking req[1:0] and rr_last, returning a one-hot winner. The fixed/round-robin choice lives inside it under the macro.

Test Plan:
- Only m0_ren, raddr 0x1000 then 0x1010 → grant=01 on the cycle after the request; raddr_mem=0x1000; 2 rvalid_mem beats reach m0_rvalid with m1_rvalid=0; grant=00 after the 2nd beat.
- m0_ren and m1_ren rise in the same cycle (fixed mode) → m1 served first (grant=10, 2 beats), 1 idle cycle, then m0 (grant=01).
- m1 read burst, then m1_wen at 0x2000 with wmask 0xFFFF and wdata 0xA5.. → RD burst completes, re-arbitration, WR passes waddr_mem, wmask_mem and wdata_mem through; 2 wvalid_mem beats reach m1_wvalid; ren_mem=0 throughout WR.
- m1 requests after m0's first beat → no pre-emption, m0 completes 2 beats, then m1 granted.
- Owner m0 drops m0_ren after 1 beat → IDLE next cycle, cnt=0; a late rvalid_mem is not forwarded.
- rstn low during beat 1 of an m1 write → all outputs 0 immediately. With ARB_ROUND_ROBIN_EN and both masters requesting continuously, grants alternate m1, m0, m1, m0.
